// File: rtl/fb_rect_writer.sv
// Solid-rectangle fill engine for the 160x120 frame buffer: one pixel write per clock.
// Optional macro FB_WRITE_VBLANK_ONLY_EN restricts pixel writes to vblank cycles.
module fb_rect_writer #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_W-1:0]    cmd_x0,
  input  logic [Y_W-1:0]    cmd_y0,
  input  logic [X_W-1:0]    cmd_w,
  input  logic [Y_W-1:0]    cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic              vblank,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren
);

  // Handshake: a command is accepted on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, and a held cmd_valid simply waits for it.
  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  localparam logic [X_W:0]    FB_W_X = (X_W+1)'(FB_W);
  localparam logic [Y_W:0]    FB_H_Y = (Y_W+1)'(FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
  localparam logic [X_W:0]    ONE_X  = (X_W+1)'(1);
  localparam logic [Y_W:0]    ONE_Y  = (Y_W+1)'(1);

  state_t              state_q;
  logic [X_W-1:0]      x0_q, w_q, x_q;
  logic [Y_W-1:0]      y0_q, h_q, y_q;
  logic [X_W:0]        x_end_q;
  logic [Y_W:0]        y_end_q;
  logic [ADDR_W-1:0]   row_base_q;
  logic [DATA_W-1:0]   color_q;
  logic                done_q, wren_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;

  logic [X_W:0]        x_sum_d, x_end_d, x_nxt_d;
  logic [Y_W:0]        y_sum_d, y_end_d, y_nxt_d;
  logic [ADDR_W-1:0]   row_base_d, pix_addr_d;
  logic                empty_d, last_x_d, last_y_d, advance_d;

  // Clip bounds are one bit wider than the fields so x0+w cannot wrap.
  always_comb begin
    x_sum_d    = {1'b0, x0_q} + {1'b0, w_q};
    y_sum_d    = {1'b0, y0_q} + {1'b0, h_q};
    x_end_d    = (x_sum_d > FB_W_X) ? FB_W_X : x_sum_d;
    y_end_d    = (y_sum_d > FB_H_Y) ? FB_H_Y : y_sum_d;
    empty_d    = (w_q == '0) || (h_q == '0) ||
                 ({1'b0, x0_q} >= FB_W_X) || ({1'b0, y0_q} >= FB_H_Y);
    row_base_d = ADDR_W'(y0_q) * FB_W_A;
    x_nxt_d    = {1'b0, x_q} + ONE_X;
    y_nxt_d    = {1'b0, y_q} + ONE_Y;
    last_x_d   = (x_nxt_d == x_end_q);
    last_y_d   = (y_nxt_d == y_end_q);
    pix_addr_d = row_base_q + ADDR_W'(x_q);
  end

`ifdef FB_WRITE_VBLANK_ONLY_EN
  assign advance_d = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign advance_d     = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          wren_q <= 1'b0;
          if (cmd_valid) begin
            x0_q    <= cmd_x0;
            y0_q    <= cmd_y0;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          x_end_q    <= x_end_d;
          y_end_q    <= y_end_d;
          x_q        <= x0_q;
          y_q        <= y0_q;
          row_base_q <= row_base_d;
          state_q    <= empty_d ? DONE : WRITE;
        end
        WRITE: begin
          if (advance_d) begin
            addr_q <= pix_addr_d;
            data_q <= color_q;
            wren_q <= 1'b1;
            if (last_x_d) begin
              x_q <= x0_q;
              if (last_y_d) begin
                state_q <= DONE;
              end else begin
                // Row stepping by addition keeps the multiplier out of the pixel loop.
                y_q        <= y_nxt_d[Y_W-1:0];
                row_base_q <= row_base_q + FB_W_A;
              end
            end else begin
              x_q <= x_nxt_d[X_W-1:0];
            end
          end else begin
            wren_q <= 1'b0;
          end
        end
        DONE: begin
          wren_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign mem_wren    = wren_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: fills, clipping, empty commands, back-to-back, reset, vblank.
module tb_fb_rect_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x0;
  logic [6:0]  cmd_y0;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        vblank = 1'b1;
  logic        busy;
  logic        done;
  logic [14:0] mem_address;
  logic [23:0] mem_data;
  logic        mem_wren;

  int checks = 0;
  int errors = 0;

  logic [14:0] wr_q[$];
  logic [23:0] wd_q[$];
  logic [14:0] exp_q[$];
  logic [23:0] exp_d_q[$];
  int          wr_base = 0;
  int          done_cnt = 0;
  int          done_base = 0;
  logic        vb_toggle = 1'b0;
  int          vb_phase = 0;

  fb_rect_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .vblank(vblank), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      wr_q.push_back(mem_address);
      wd_q.push_back(mem_data);
    end
    if (done === 1'b1) done_cnt++;
  end

  // vblank pattern: 3 cycles high, 3 cycles low while enabled, else held high.
  always @(posedge clk) begin
    #1;
    if (vb_toggle) begin
      vb_phase = (vb_phase == 5) ? 0 : vb_phase + 1;
      vblank   = (vb_phase < 3);
    end else begin
      vb_phase = 0;
      vblank   = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] w,
                      input logic [6:0] h, input logic [23:0] c);
    int n;
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic expect_px(input int a, input logic [23:0] d);
    exp_q.push_back(15'(a));
    exp_d_q.push_back(d);
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = wr_q.size() - wr_base;
    chk({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, 32'(wr_q[wr_base+i]), 32'(exp_q[i]));
      chk({tag, "_data"}, 32'(wd_q[wr_base+i]), 32'(exp_d_q[i]));
    end
    wr_base = wr_q.size();
    exp_q.delete();
    exp_d_q.delete();
  endtask

  task automatic check_dones(input string tag, input int exp_n);
    chk(tag, 32'(done_cnt - done_base), 32'(exp_n));
    done_base = done_cnt;
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_wren",  32'(mem_wren),  32'd0);
    chk("rst_addr",  32'(mem_address), 32'd0);
    chk("rst_data",  32'(mem_data),  32'd0);
    rst = 1'b0;
    tick();

    // Basic fill with exact timing
    send(8'd2, 7'd3, 8'd3, 7'd2, 24'hFF0000);
    chk("basic_busy_accept",  32'(busy),      32'd1);
    chk("basic_ready_accept", 32'(cmd_ready), 32'd0);
    tick();
    chk("basic_wren_setup", 32'(mem_wren), 32'd0);
    tick();
    chk("basic_wren_first", 32'(mem_wren), 32'd1);
    chk("basic_addr_first", 32'(mem_address), 32'd482);
    repeat (5) tick();
    chk("basic_done_early", 32'(done), 32'd0);
    tick();
    chk("basic_done_pulse", 32'(done), 32'd1);
    chk("basic_busy_fall",  32'(busy), 32'd0);
    tick();
    chk("basic_done_once",  32'(done), 32'd0);
    expect_px(482, 24'hFF0000); expect_px(483, 24'hFF0000); expect_px(484, 24'hFF0000);
    expect_px(642, 24'hFF0000); expect_px(643, 24'hFF0000); expect_px(644, 24'hFF0000);
    check_writes("basic");
    check_dones("basic_dones", 1);

    // Clipping at the bottom-right corner
    send(8'd158, 7'd119, 8'd5, 7'd4, 24'h00FF00);
    wait_done(n);
    tick();
    expect_px(19198, 24'h00FF00); expect_px(19199, 24'h00FF00);
    check_writes("clip");
    check_dones("clip_dones", 1);

    // Empty: zero width
    send(8'd5, 7'd5, 8'd0, 7'd3, 24'h123456);
    tick();
    chk("empty_w_done_early", 32'(done), 32'd0);
    tick();
    chk("empty_w_done", 32'(done), 32'd1);
    tick(); tick();
    check_writes("empty_w");

    // Empty: x0 off screen
    send(8'd160, 7'd0, 8'd4, 7'd4, 24'h654321);
    tick();
    chk("empty_x_done_early", 32'(done), 32'd0);
    tick();
    chk("empty_x_done", 32'(done), 32'd1);
    tick(); tick();
    check_writes("empty_x");
    check_dones("empty_dones", 2);

    // Back-to-back with cmd_valid held high
    send(8'd0, 7'd0, 8'd1, 7'd1, 24'hAAAAAA);
    cmd_x0 = 8'd159; cmd_y0 = 7'd119; cmd_w = 8'd1; cmd_h = 7'd1; cmd_color = 24'h555555;
    cmd_valid = 1'b1;
    chk("b2b_ready0", 32'(cmd_ready), 32'd0);
    tick();
    chk("b2b_ready1", 32'(cmd_ready), 32'd0);
    tick();
    chk("b2b_ready2", 32'(cmd_ready), 32'd0);
    send(8'd159, 7'd119, 8'd1, 7'd1, 24'h555555);
    wait_done(n);
    tick();
    expect_px(0, 24'hAAAAAA); expect_px(19199, 24'h555555);
    check_writes("b2b");
    check_dones("b2b_dones", 2);

    // Reset in the middle of a 10x10 fill
    send(8'd10, 7'd10, 8'd10, 7'd10, 24'h0000FF);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    chk("midrst_wren",  32'(mem_wren),    32'd0);
    chk("midrst_ready", 32'(cmd_ready),   32'd1);
    chk("midrst_busy",  32'(busy),        32'd0);
    chk("midrst_addr",  32'(mem_address), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) expect_px(1610 + i, 24'h0000FF);
    check_writes("midrst");
    check_dones("midrst_dones", 0);
    send(8'd1, 7'd1, 8'd2, 7'd1, 24'hC0FFEE);
    wait_done(n);
    tick();
    expect_px(161, 24'hC0FFEE); expect_px(162, 24'hC0FFEE);
    check_writes("after_rst");
    check_dones("after_rst_dones", 1);

    // vblank toggling during a 4x1 fill
    vb_toggle = 1'b1;
    send(8'd20, 7'd0, 8'd4, 7'd1, 24'h808080);
    wait_done(n);
`ifdef FB_WRITE_VBLANK_ONLY_EN
    chk("vb_stalled", 32'(n >= 9), 32'd1);
`else
    chk("vb_ignored_latency", 32'(n), 32'd6);
`endif
    vb_toggle = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) expect_px(20 + i, 24'h808080);
    check_writes("vb");
    check_dones("vb_dones", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
- Drawing engine that fills solid axis-aligned rectangles into the reduced-resolution VGA frame buffer RAM.
- Drives the RAM write port (address/data/wren), one pixel per clock.
- It is the producer side of the frame buffer; the display read FSM is the consumer.
- Game logic (paddles, ball, background clears) issues rectangle commands over a valid/ready handshake.

Parameters:
- FB_W, 160, frame buffer width in pixels (display x / 4)
- FB_H, 120, frame buffer height in pixels (display y / 4)
- X_W, 8, width of x coordinate/width fields
- Y_W, 7, width of y coordinate/height fields
- ADDR_W, 15, frame buffer address width
- DATA_W, 24, pixel width, {R[7:0],G[7:0],B[7:0]}

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  rectangle command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0  in  X_W  left column
- cmd_y0  in  Y_W  top row
- cmd_w  in  X_W  width in pixels
- cmd_h  in  Y_W  height in pixels
- cmd_color  in  DATA_W  fill colour
- vblank  in  1  display is outside the active area; used only with the optional feature
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes
- mem_address  out  ADDR_W  frame buffer address
- mem_data  out  DATA_W  frame buffer write data
- mem_wren  out  1  frame buffer write enable

Behaviour:
- Reset values, applied on the first rising clk edge with rst=1 (synchronous):
  - state IDLE
  - cmd_ready=1, busy=0, done=0, mem_wren=0
  - mem_address=0, mem_data=0
- Reset mid-command: abandons the command at that edge, with no further writes and no done pulse.
- cmd_ready = (state==IDLE). Accept occurs on the edge where cmd_valid && cmd_ready. The command fields are latched on that edge.
- States:
  - IDLE: wait for accept, then go to SETUP.
  - SETUP (1 cycle):
    - x_end = min(x0+w, FB_W) and y_end = min(y0+h, FB_H), computed at X_W+1 / Y_W+1 bits so there is no wrap.
    - Empty rectangle (w==0, h==0, x0>=FB_W or y0>=FB_H): go to DONE.
    - Otherwise load x=x0, y=y0, row_base=y0*FB_W, then go to WRITE.
  - WRITE:
    - Each cycle registers mem_address=row_base+x, mem_data=color, mem_wren=1.
    - x increments. When x+1==x_end: x=x0, y increments, row_base += FB_W (no multiplier in the loop).
    - After the pixel (x_end-1, y_end-1) is issued, go to DONE.
  - DONE (1 cycle): mem_wren=0, done=1, then IDLE.
- Latency: a non-empty clipped rectangle of Wc×Hc takes 1 accept + 1 SETUP + Wc·Hc WRITE + 1 DONE cycles. The first mem_wren is high 2 edges after the accept edge.
- busy=1 in SETUP, WRITE and DONE.
- mem_wren is 0 in every state except WRITE. mem_address and mem_data hold their last values outside WRITE.
- Address range is always < FB_W·FB_H (19200).
- cmd_valid while busy: ignored. The command stays pending until IDLE and is then accepted.
- Commands are never merged or dropped.

Optional Feature:
- Macro FB_WRITE_VBLANK_ONLY_EN.
- Defined: WRITE advances only in cycles where vblank=1. When vblank=0, mem_wren=0 and x, y and row_base hold, so there is no tearing. SETUP and DONE are not gated.
- Undefined: vblank is ignored and WRITE advances every cycle.

Test Plan:
- Basic fill: x0=2, y0=3, w=3, h=2, color=FF0000 -> six writes at addresses 482, 483, 484, 642, 643, 644 with data FF0000. done pulses 8 cycles after the accept edge. busy falls with done.
- Clipping: x0=158, y0=119, w=5, h=4 -> exactly two writes at 19198 and 19199, then done. No address ≥ 19200.
- Empty command: w=0 (and separately x0=160) -> mem_wren never high. done pulses 2 cycles after accept.
- Back-to-back: cmd_valid held high with two 1×1 commands at (0,0) and (159,119) -> cmd_ready=0 during the first command. Writes go to 0, then 19199, with two done pulses and no lost command.
- Reset mid-op: assert rst during a 10×10 fill after 5 writes -> mem_wren=0 and cmd_ready=1 after that edge. No done pulse. A new command then runs normally.
- Feature on: vblank toggles 3 cycles high / 3 cycles low during a 4×1 fill -> writes occur only when vblank=1, in address order, with no duplicates.
